// File: rtl/elliptic_curve_structs_pkg.sv
// ----------------------------------------------------------------------------
// elliptic_curve_structs
//   Shared types for the ECDSA sign controller and its datapath:
//     modop_t      - operation code driven to the shared modular ALU
//     modstep_t    - destination register of a modop result
//     sign_state_t - sign controller state encoding
//   Helpers classify states into wait states (start/done handshake) and the
//   four modop states.
// ----------------------------------------------------------------------------
package elliptic_curve_structs;

  // MOD_NOP is the idle encoding driven outside any modop state.
  typedef enum logic [1:0] {
    MOD_NOP = 2'd0,
    MOD_ADD = 2'd1,
    MOD_MUL = 2'd2,
    MOD_INV = 2'd3
  } modop_t;

  typedef enum logic [1:0] {
    STEP_KINV  = 2'd0,
    STEP_T_RD  = 2'd1,
    STEP_T_ZRD = 2'd2,
    STEP_S     = 2'd3
  } modstep_t;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_HASH  = 4'd1,
    ST_NONCE = 4'd2,
    ST_PMUL  = 4'd3,
    ST_CHK_R = 4'd4,
    ST_INV   = 4'd5,
    ST_RD    = 4'd6,
    ST_ZRD   = 4'd7,
    ST_SMUL  = 4'd8,
    ST_CHK_S = 4'd9,
    ST_RETRY = 4'd10,
    ST_DONE  = 4'd11,
    ST_FAIL  = 4'd12
  } sign_state_t;

  function automatic logic is_modop_state(sign_state_t s);
    return s inside {ST_INV, ST_RD, ST_ZRD, ST_SMUL};
  endfunction

  function automatic logic is_wait_state(sign_state_t s);
    return (s inside {ST_HASH, ST_NONCE, ST_PMUL}) || is_modop_state(s);
  endfunction

endpackage

// File: rtl/ecdsa_sign_control_wait_timer.sv
// ----------------------------------------------------------------------------
// ecdsa_sign_wait_timer
//   Per-handshake watchdog for the sign controller. Counts cycles spent in the
//   current wait state; the count is 0 in the entry (start-pulse) cycle, so
//   expired_o rises in the cycle the count reaches TIMEOUT_CYCLES-1.
//   Only instantiated when ECDSA_SIGN_TIMEOUT_EN is defined.
// Ports
//   clk, reset  clock, synchronous active-high reset
//   wait_i      controller is in a wait state
//   entry_i     first cycle of a wait state (start pulse is high)
//   expired_o   watchdog limit reached this cycle
// ----------------------------------------------------------------------------
module ecdsa_sign_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1 << 20
) (
  input  logic clk,
  input  logic reset,
  input  logic wait_i,
  input  logic entry_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d, cur;

  // Back-to-back wait states (INV->RD...) never pass through a non-wait
  // cycle, so the entry cycle overrides the stale count from the last state.
  assign cur       = entry_i ? '0 : cnt_q;
  assign cnt_d     = wait_i ? cur + CNT_W'(1) : '0;
  assign expired_o = wait_i && (cur == LAST);

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ecdsa_sign_control.sv
// ----------------------------------------------------------------------------
// ecdsa_sign_control
//   Sequencing FSM for ECDSA signature generation:
//     z = H(m); k = RNG; r = (k*G).x mod n;
//     s = k^-1 * (z + r*d) mod n via INV, MUL, ADD, MUL on the shared ALU.
//   r==0 or s==0 draws a fresh nonce (z is kept) up to MAX_RETRY attempts.
//   Control only; the datapath holds operands and reports r_zero / s_zero.
//   Optional feature macro: ECDSA_SIGN_TIMEOUT_EN adds a per-handshake
//   watchdog (TIMEOUT_CYCLES) that ends the run in FAIL.
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   init_sign_i                   start a signature (sampled in IDLE only)
//   busy_o                        high outside IDLE
//   done_sign_o / sign_error_o    1-cycle completion pulse / error qualifier
//   start_hash_o  done_hash_i  load_hash_o   hash core handshake, store z
//   start_nonce_o done_nonce_i load_k_o      nonce RNG handshake, store k
//   start_pmul_o  done_pmul_i  load_r_o      point multiply, store r
//   r_zero_i                                 r==0 flag, read in CHK_R
//   start_modop_o done_modop_i load_modop_o  modular ALU handshake
//   modop_o, modop_step_o                    ALU op and result destination
//   s_zero_i                                 s==0 flag, read in CHK_S
// ----------------------------------------------------------------------------
module ecdsa_sign_control
  import elliptic_curve_structs::*;
#(
  parameter int unsigned MAX_RETRY      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1 << 20
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     init_sign_i,
  output logic     busy_o,
  output logic     done_sign_o,
  output logic     sign_error_o,
  output logic     start_hash_o,
  input  logic     done_hash_i,
  output logic     load_hash_o,
  output logic     start_nonce_o,
  input  logic     done_nonce_i,
  output logic     load_k_o,
  output logic     start_pmul_o,
  input  logic     done_pmul_i,
  output logic     load_r_o,
  input  logic     r_zero_i,
  output logic     start_modop_o,
  output modop_t   modop_o,
  output modstep_t modop_step_o,
  input  logic     done_modop_i,
  output logic     load_modop_o,
  input  logic     s_zero_i
);

  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

  if (MAX_RETRY < 1 || TIMEOUT_CYCLES < 2) begin : g_cfg_bad
    $error("ecdsa_sign_control: MAX_RETRY must be >= 1 and TIMEOUT_CYCLES >= 2");
  end

  sign_state_t      state_q;
  logic [RETRY_W-1:0] retry_q;
  logic             busy_q, done_q, error_q;
  logic             start_hash_q, start_nonce_q, start_pmul_q, start_modop_q;
  modop_t           modop_q;
  modstep_t         step_q;

  // A done is honoured only after the start cycle of its own state; the
  // start pulse being high marks that start cycle.
  logic hash_ack, nonce_ack, pmul_ack, modop_ack, ack_any, start_any, tmo;
  logic last_try;

  assign hash_ack  = (state_q == ST_HASH)  && !start_hash_q  && done_hash_i;
  assign nonce_ack = (state_q == ST_NONCE) && !start_nonce_q && done_nonce_i;
  assign pmul_ack  = (state_q == ST_PMUL)  && !start_pmul_q  && done_pmul_i;
  assign modop_ack = is_modop_state(state_q) && !start_modop_q && done_modop_i;
  assign ack_any   = hash_ack | nonce_ack | pmul_ack | modop_ack;
  assign start_any = start_hash_q | start_nonce_q | start_pmul_q | start_modop_q;

  assign last_try = (({1'b0, retry_q} + (RETRY_W + 1)'(1)) == (RETRY_W + 1)'(MAX_RETRY));

`ifdef ECDSA_SIGN_TIMEOUT_EN
  ecdsa_sign_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .wait_i   (is_wait_state(state_q)),
    .entry_i  (start_any),
    .expired_o(tmo)
  );
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      retry_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      start_hash_q  <= 1'b0;
      start_nonce_q <= 1'b0;
      start_pmul_q  <= 1'b0;
      start_modop_q <= 1'b0;
      modop_q       <= MOD_NOP;
      step_q        <= STEP_KINV;
    end else begin
      start_hash_q  <= 1'b0;
      start_nonce_q <= 1'b0;
      start_pmul_q  <= 1'b0;
      start_modop_q <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;

      case (state_q)
        ST_IDLE: if (init_sign_i) begin
          state_q      <= ST_HASH;
          start_hash_q <= 1'b1;
          retry_q      <= '0;
          busy_q       <= 1'b1;
        end
        ST_HASH: if (hash_ack) begin
          state_q       <= ST_NONCE;
          start_nonce_q <= 1'b1;
        end
        ST_NONCE: if (nonce_ack) begin
          state_q      <= ST_PMUL;
          start_pmul_q <= 1'b1;
        end
        ST_PMUL: if (pmul_ack) state_q <= ST_CHK_R;
        ST_CHK_R: begin
          if (r_zero_i) begin
            state_q <= ST_RETRY;
          end else begin
            state_q       <= ST_INV;
            start_modop_q <= 1'b1;
            modop_q       <= MOD_INV;
            step_q        <= STEP_KINV;
          end
        end
        ST_INV: if (modop_ack) begin
          state_q       <= ST_RD;
          start_modop_q <= 1'b1;
          modop_q       <= MOD_MUL;
          step_q        <= STEP_T_RD;
        end
        ST_RD: if (modop_ack) begin
          state_q       <= ST_ZRD;
          start_modop_q <= 1'b1;
          modop_q       <= MOD_ADD;
          step_q        <= STEP_T_ZRD;
        end
        ST_ZRD: if (modop_ack) begin
          state_q       <= ST_SMUL;
          start_modop_q <= 1'b1;
          modop_q       <= MOD_MUL;
          step_q        <= STEP_S;
        end
        ST_SMUL: if (modop_ack) begin
          state_q <= ST_CHK_S;
          modop_q <= MOD_NOP;
          step_q  <= STEP_KINV;
        end
        ST_CHK_S: begin
          if (s_zero_i) begin
            state_q <= ST_RETRY;
          end else begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_RETRY: begin
          if (last_try) begin
            state_q <= ST_FAIL;
            done_q  <= 1'b1;
            error_q <= 1'b1;
          end else begin
            state_q       <= ST_NONCE;
            start_nonce_q <= 1'b1;
            retry_q       <= retry_q + RETRY_W'(1);
          end
        end
        ST_DONE, ST_FAIL: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      // Watchdog overrides the case above; a done in the same cycle wins.
      if (tmo && !ack_any) begin
        state_q <= ST_FAIL;
        done_q  <= 1'b1;
        error_q <= 1'b1;
        modop_q <= MOD_NOP;
        step_q  <= STEP_KINV;
      end
    end
  end

  assign busy_o        = busy_q;
  assign done_sign_o   = done_q;
  assign sign_error_o  = error_q;
  assign start_hash_o  = start_hash_q;
  assign start_nonce_o = start_nonce_q;
  assign start_pmul_o  = start_pmul_q;
  assign start_modop_o = start_modop_q;
  assign modop_o       = modop_q;
  assign modop_step_o  = step_q;
  assign load_hash_o   = hash_ack;
  assign load_k_o      = nonce_ack;
  assign load_r_o      = pmul_ack;
  assign load_modop_o  = modop_ack;

endmodule

// File: tb/tb_ecdsa_sign_control.sv
// ----------------------------------------------------------------------------
// tb_ecdsa_sign_control
//   Scoreboard bench: each signing run pushes its expected outcome (error
//   flag, handshake pulse counts, latency, modop sequence) and the monitor
//   pops and compares when done_sign fires. A responder models the hash core,
//   RNG, point multiplier and modular ALU with a configurable done delay.
// ----------------------------------------------------------------------------
module tb_ecdsa_sign_control;
  import elliptic_curve_structs::*;

  localparam int unsigned MAX_RETRY = 4;
  localparam int unsigned TMO       = 16;
  localparam logic [15:0] EXP_OPS   = {MOD_INV, STEP_KINV, MOD_MUL, STEP_T_RD,
                                       MOD_ADD, STEP_T_ZRD, MOD_MUL, STEP_S};

  typedef struct {
    logic err;
    int   hash_n;
    int   nonce_n;
    int   pmul_n;
    int   lat;
    int   tmo_lat;
    logic chk_ops;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic init_sign = 1'b0;
  logic busy, done_sign, sign_error;
  logic start_hash, load_hash, start_nonce, load_k, start_pmul, load_r;
  logic start_modop, load_modop;
  logic [1:0] modop, modop_step;
  logic done_hash, done_nonce, done_pmul, done_modop, r_zero, s_zero;
  logic rsp_hash = 1'b0, rsp_nonce = 1'b0, rsp_pmul = 1'b0, rsp_modop = 1'b0;
  logic stray_pmul = 1'b0, stray_modop = 1'b0;
  logic [7:0] rz_mask = 8'h00, sz_mask = 8'h00;
  logic [14:0] outs;

  int dly = 1;
  bit no_pmul = 1'b0;
  int total = 0, bad = 0;
  int cyc = 0, t0 = 0, t_pmul = 0;
  int hash_n = 0, nonce_n = 0, pmul_n = 0, done_cnt = 0;
  logic [15:0] ops_log = '0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  assign done_hash  = rsp_hash;
  assign done_nonce = rsp_nonce;
  assign done_pmul  = rsp_pmul | stray_pmul;
  assign done_modop = rsp_modop | stray_modop;

  function automatic logic pick(input logic [7:0] m, input int n);
    int i;
    i = (n > 0) ? n - 1 : 0;
    return m[i[2:0]];
  endfunction

  assign r_zero = pick(rz_mask, pmul_n);
  assign s_zero = pick(sz_mask, pmul_n);
  assign outs = {busy, done_sign, sign_error, start_hash, load_hash, start_nonce,
                 load_k, start_pmul, load_r, start_modop, modop, modop_step, load_modop};

  ecdsa_sign_control #(
    .MAX_RETRY     (MAX_RETRY),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .init_sign_i  (init_sign),
    .busy_o       (busy),
    .done_sign_o  (done_sign),
    .sign_error_o (sign_error),
    .start_hash_o (start_hash),
    .done_hash_i  (done_hash),
    .load_hash_o  (load_hash),
    .start_nonce_o(start_nonce),
    .done_nonce_i (done_nonce),
    .load_k_o     (load_k),
    .start_pmul_o (start_pmul),
    .done_pmul_i  (done_pmul),
    .load_r_o     (load_r),
    .r_zero_i     (r_zero),
    .start_modop_o(start_modop),
    .modop_o      (modop),
    .modop_step_o (modop_step),
    .done_modop_i (done_modop),
    .load_modop_o (load_modop),
    .s_zero_i     (s_zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, want);
    end
  endtask

  function automatic exp_t mk_exp(input logic err, input int h, input int n, input int p,
                                  input int lat, input int tlat, input logic ops);
    exp_t e;
    e.err = err; e.hash_n = h; e.nonce_n = n; e.pmul_n = p;
    e.lat = lat; e.tmo_lat = tlat; e.chk_ops = ops;
    return e;
  endfunction

  // Responder: done arrives 'dly' cycles after the start pulse (1 = earliest).
  int th = 0, tn = 0, tp = 0, tm = 0;
  always @(negedge clk) begin
    rsp_hash = 1'b0; rsp_nonce = 1'b0; rsp_pmul = 1'b0; rsp_modop = 1'b0;
    if (reset) begin
      th = 0; tn = 0; tp = 0; tm = 0;
    end else begin
      if (start_hash) th = dly;
      else if (th > 0) begin th--; rsp_hash = (th == 0); end
      if (start_nonce) tn = dly;
      else if (tn > 0) begin tn--; rsp_nonce = (tn == 0); end
      if (start_pmul) tp = no_pmul ? 0 : dly;
      else if (tp > 0) begin tp--; rsp_pmul = (tp == 0); end
      if (start_modop) tm = dly;
      else if (tm > 0) begin tm--; rsp_modop = (tm == 0); end
    end
  end

  // Monitor: per-run counters clear when init is accepted (posedge, IDLE);
  // pulses are counted and the scoreboard popped at negedge.
  always @(clk) begin
    if (clk) begin
      cyc++;
      if (!reset && !busy && init_sign) begin
        t0 = cyc; hash_n = 0; nonce_n = 0; pmul_n = 0; ops_log = '0;
      end
    end else begin
      if (start_hash)  hash_n++;
      if (start_nonce) nonce_n++;
      if (start_pmul) begin pmul_n++; t_pmul = cyc; end
      if (start_modop) ops_log = {ops_log[11:0], modop, modop_step};
      if (done_sign) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sign_error", sign_error, e.err);
          chk("hash_pulses", hash_n, e.hash_n);
          chk("nonce_pulses", nonce_n, e.nonce_n);
          chk("pmul_pulses", pmul_n, e.pmul_n);
          if (e.lat > 0)     chk("latency", cyc - t0 + 1, e.lat);
          if (e.tmo_lat > 0) chk("timeout_latency", cyc - t_pmul, e.tmo_lat);
          if (e.chk_ops)     chk("modop_seq", ops_log, EXP_OPS);
        end
        done_cnt++;
      end
    end
  end

  task automatic wait_done(input int n0);
    for (int i = 0; i < 400 && done_cnt == n0; i++) @(negedge clk);
    if (done_cnt == n0) begin
      chk("run_timeout", 32'd0, 32'd1);
      if (sbq.size() > 0) void'(sbq.pop_back());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_sign(input exp_t e, input bit poke_pmul);
    int n0;
    sbq.push_back(e);
    n0 = done_cnt;
    @(negedge clk); init_sign = 1'b1;
    @(negedge clk); init_sign = 1'b0;
    if (poke_pmul) begin
      for (int i = 0; i < 100 && pmul_n == 0; i++) @(negedge clk);
      chk("reach_pmul", pmul_n, 32'd1);
      init_sign = 1'b1;
      @(negedge clk); init_sign = 1'b0;
    end
    wait_done(n0);
  endtask

  initial begin
    bit found;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs, 15'd0);
    reset = 1'b0;
    @(negedge clk);

    // nominal, earliest dones
    dly = 1;
    run_sign(mk_exp(1'b0, 1, 1, 1, 17, 0, 1'b1), 1'b0);
    // slower responders
    dly = 3;
    run_sign(mk_exp(1'b0, 1, 1, 1, 0, 0, 1'b1), 1'b0);
    // r==0 on first attempt: new nonce, no re-hash
    dly = 1; rz_mask = 8'h01;
    run_sign(mk_exp(1'b0, 1, 2, 2, 0, 0, 1'b1), 1'b0);
    // s==0 every attempt: retries exhausted
    rz_mask = 8'h00; sz_mask = 8'hFF;
    run_sign(mk_exp(1'b1, 1, MAX_RETRY, MAX_RETRY, 0, 0, 1'b0), 1'b0);
    sz_mask = 8'h00;

    // stray dones in IDLE
    stray_pmul = 1'b1; stray_modop = 1'b1;
    #1;
    chk("stray_load_r", load_r, 1'b0);
    chk("stray_load_modop", load_modop, 1'b0);
    @(negedge clk);
    stray_pmul = 1'b0; stray_modop = 1'b0;
    chk("stray_idle", {busy, start_hash, start_pmul}, 3'd0);

    // init_sign in PMUL is ignored
    dly = 4;
    run_sign(mk_exp(1'b0, 1, 1, 1, 0, 0, 1'b1), 1'b1);

    // reset in ZRD on the second attempt (retry count non-zero)
    dly = 1; rz_mask = 8'h01;
    @(negedge clk); init_sign = 1'b1;
    @(negedge clk); init_sign = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (start_modop && modop_step == STEP_T_ZRD) found = 1'b1;
      else @(negedge clk);
    end
    chk("reach_zrd", found, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrun_reset_outputs", outs, 15'd0);
    reset = 1'b0;
    rz_mask = 8'h00; sz_mask = 8'hFF;
    run_sign(mk_exp(1'b1, 1, MAX_RETRY, MAX_RETRY, 0, 0, 1'b0), 1'b0);
    sz_mask = 8'h00;

`ifdef ECDSA_SIGN_TIMEOUT_EN
    // withheld done_pmul: watchdog ends the run
    no_pmul = 1'b1;
    run_sign(mk_exp(1'b1, 1, 1, 1, 0, TMO, 1'b0), 1'b0);
    no_pmul = 1'b0;
`endif

    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
